// File: rtl/pq_key_select_tree_if.sv
// Vector-in / winner-out handshake bundle for pq_key_select_tree.
// The slave modport is the selector's view; master is the producer/consumer side.
interface pq_key_select_tree_if #(
    parameter int N     = 8,
    parameter int KEY_W = 8,
    parameter int VAL_W = 8
);
    localparam int LEVELS = $clog2(N);

    logic                   in_valid;
    logic                   in_ready;
    logic [N*KEY_W-1:0]     in_key;
    logic [N*VAL_W-1:0]     in_val;
    logic [N-1:0]           in_occ;
    logic                   in_max;
    logic                   out_valid;
    logic                   out_ready;
    logic [KEY_W-1:0]       out_key;
    logic [VAL_W-1:0]       out_val;
    logic [LEVELS-1:0]      out_idx;
    logic                   out_empty;

    modport master (
        output in_valid, in_key, in_val, in_occ, in_max, out_ready,
        input  in_ready, out_valid, out_key, out_val, out_idx, out_empty
    );

    modport slave (
        input  in_valid, in_key, in_val, in_occ, in_max, out_ready,
        output in_ready, out_valid, out_key, out_val, out_idx, out_empty
    );
endinterface

// File: rtl/pq_key_select_tree.sv
// Pipelined N-way min/max key selector: a binary tournament with one register
// stage per tree level, global stall, lower index wins on equal keys.
module pq_key_select_tree #(
    parameter int N     = 8,
    parameter int KEY_W = 8,
    parameter int VAL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pq_key_select_tree_if.slave  bus
);
    localparam int LEVELS = $clog2(N);
    localparam int NODES  = N - 1;

    logic              advance;
    logic [LEVELS-1:0] vld_d;
    logic [LEVELS-1:0] vld_q;

    // B replaces A only when strictly better, so ties keep the lower index.
    function automatic logic b_wins(input logic a_occ, input logic b_occ,
                                    input logic [KEY_W-1:0] a_key,
                                    input logic [KEY_W-1:0] b_key,
                                    input logic max_mode);
        if (a_occ && b_occ)
            return max_mode ? (b_key > a_key) : (b_key < a_key);
        return b_occ;
    endfunction

    always_comb begin
        advance  = !vld_q[LEVELS-1] || bus.out_ready;
        vld_d[0] = bus.in_valid;
        for (int s = 1; s < LEVELS; s++)
            vld_d[s] = vld_q[s-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_q <= '0;
        else if (advance)
            vld_q <= vld_d;
    end

    // Mode bit of the vector held in stage s; the last stage never needs it.
    for (genvar s = 0; s < LEVELS - 1; s++) begin : g_mode
        logic max_d;
        logic max_q;
        if (s == 0) begin : g_first
            always_comb max_d = bus.in_max;
        end else begin : g_next
            always_comb max_d = g_mode[s-1].max_q;
        end
        always_ff @(posedge clk) begin
            if (!rst_n)
                max_q <= 1'b0;
            else if (advance)
                max_q <= max_d;
        end
    end

    // Heap-ordered tree: node k reduces children 2k and 2k+1; indices >= N are inputs.
    for (genvar k = 1; k <= NODES; k++) begin : g_node
        localparam int S = LEVELS - $clog2(k + 1);

        logic [KEY_W-1:0]  a_key, b_key, key_d, key_q;
        logic [VAL_W-1:0]  a_val, b_val, val_d, val_q;
        logic [LEVELS-1:0] a_idx, b_idx, idx_d, idx_q;
        logic              a_occ, b_occ, occ_d, occ_q;
        logic              mode, pick_b;

        if (2 * k >= N) begin : g_leaf
            localparam int IA = 2 * k - N;
            assign a_key = bus.in_key[IA*KEY_W +: KEY_W];
            assign b_key = bus.in_key[(IA+1)*KEY_W +: KEY_W];
            assign a_val = bus.in_val[IA*VAL_W +: VAL_W];
            assign b_val = bus.in_val[(IA+1)*VAL_W +: VAL_W];
            assign a_occ = bus.in_occ[IA];
            assign b_occ = bus.in_occ[IA+1];
            assign a_idx = LEVELS'(IA);
            assign b_idx = LEVELS'(IA + 1);
            assign mode  = bus.in_max;
        end else begin : g_inner
            assign a_key = g_node[2*k].key_q;
            assign b_key = g_node[2*k+1].key_q;
            assign a_val = g_node[2*k].val_q;
            assign b_val = g_node[2*k+1].val_q;
            assign a_occ = g_node[2*k].occ_q;
            assign b_occ = g_node[2*k+1].occ_q;
            assign a_idx = g_node[2*k].idx_q;
            assign b_idx = g_node[2*k+1].idx_q;
            assign mode  = g_mode[S-1].max_q;
        end

        always_comb begin
            pick_b = b_wins(a_occ, b_occ, a_key, b_key, mode);
            occ_d  = a_occ | b_occ;
            key_d  = '0;
            val_d  = '0;
            idx_d  = '0;
            if (occ_d) begin
                key_d = pick_b ? b_key : a_key;
                val_d = pick_b ? b_val : a_val;
                idx_d = pick_b ? b_idx : a_idx;
            end
        end

        // Stage S boundary: candidate payload follows the stage valid, not reset.
        always_ff @(posedge clk) begin
            if (advance) begin
                key_q <= key_d;
                val_q <= val_d;
                idx_q <= idx_d;
                occ_q <= occ_d;
            end
        end
    end

    // Payload is qualified by the final stage valid so reset and bubbles read as zero.
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[LEVELS-1];
    assign bus.out_empty = vld_q[LEVELS-1] & ~g_node[1].occ_q;
    assign bus.out_key   = vld_q[LEVELS-1] ? g_node[1].key_q : '0;
    assign bus.out_val   = vld_q[LEVELS-1] ? g_node[1].val_q : '0;
    assign bus.out_idx   = vld_q[LEVELS-1] ? g_node[1].idx_q : '0;
endmodule
